acq_trigger_ctrl: RTL and testbench

// - Acquisition sequencer between the ADC sample stream and the display frame buffer.
// - Arms on run/single, detects a rising-edge crossing of the trigger level (auto-trigger on timeout).
// - Writes one decimated frame of DEPTH samples, then holds it until the display acknowledges.
// - Trigger level, decimation and auto timeout come from the user-interface block (trigger, count_adc, trig_clk).

---
 rtl/acq_trigger_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_acq_trigger_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_trigger_ctrl.sv
// acq_trigger_ctrl: acquisition sequencer between the ADC stream and the frame buffer.
// Arms, triggers on a rising crossing (or timeout), writes one decimated frame, holds it.
module acq_trigger_ctrl #(
   parameter int ADC_W  = 12,
   parameter int ADDR_W = 10,
   parameter int TO_SH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADC_W-1:0]  adc_data,
   input  logic              adc_valid,
   input  logic [ADC_W-1:0]  trigger,
   input  logic [11:0]       count_adc,
   input  logic [11:0]       trig_clk,
   input  logic              run,
   input  logic              single,
   input  logic              frame_ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADC_W-1:0]  wr_data,
   output logic              frame_ready,
   output logic              busy,
   output logic              auto_trig
);

   localparam int TO_W = 20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAP,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADC_W-1:0]    prev_q, prev_d;
   logic                prev_ok_q, prev_ok_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                one_shot_q, one_shot_d;
   logic [11:0]         dec_q, dec_d;
   logic [11:0]         dec_cnt_q, dec_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADC_W-1:0]    wr_data_q, wr_data_d;
   logic                frame_ready_q, frame_ready_d;
   logic                busy_q, busy_d;
   logic                auto_trig_q, auto_trig_d;

   logic [TO_W-1:0]     to_inc;
   logic [TO_W-1:0]     to_lim;
   logic [ADDR_W-1:0]   addr_inc;
   logic                crossed;
   logic                timed_out;
   logic                arm;

   // Trigger qualification: live level against held previous sample, saturating timeout
   always_comb begin
      to_inc    = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
      to_lim    = TO_W'(trig_clk) << TO_SH;
      crossed   = prev_ok_q & (prev_q < trigger) & (adc_data >= trigger);
      timed_out = (trig_clk != 12'd0) & (to_inc >= to_lim);
      addr_inc  = addr_q + ADDR_W'(1);
   end

   // Sequencer next state and registered-output values
   always_comb begin
      state_d       = state_q;
      prev_d        = prev_q;
      prev_ok_d     = prev_ok_q;
      to_cnt_d      = to_cnt_q;
      one_shot_d    = one_shot_q;
      dec_d         = dec_q;
      dec_cnt_d     = dec_cnt_q;
      addr_d        = addr_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_ready_d = frame_ready_q;
      auto_trig_d   = auto_trig_q;
      arm           = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (run | single) arm = 1'b1;
         end
         S_WAIT: begin
            if (adc_valid) begin
               prev_d    = adc_data;
               prev_ok_d = 1'b1;
               to_cnt_d  = to_inc;
               if (crossed | timed_out) begin
                  state_d     = S_CAP;
                  auto_trig_d = ~crossed;
                  wr_en_d     = 1'b1;
                  wr_addr_d   = '0;
                  wr_data_d   = adc_data;
                  addr_d      = '0;
                  dec_d       = (count_adc == 12'd0) ? 12'd1 : count_adc;
                  dec_cnt_d   = '0;
               end
            end
         end
         S_CAP: begin
            if (adc_valid) begin
               if (dec_cnt_q == dec_q - 12'd1) begin
                  dec_cnt_d = '0;
                  addr_d    = addr_inc;
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_inc;
                  wr_data_d = adc_data;
                  if (addr_inc == '1) begin
                     state_d       = S_DONE;
                     frame_ready_d = 1'b1;
                  end
               end else begin
                  dec_cnt_d = dec_cnt_q + 12'd1;
               end
            end
         end
         S_DONE: begin
            if (frame_ack & frame_ready_q) begin
               frame_ready_d = 1'b0;
               if (run & ~one_shot_q) arm = 1'b1;
               else state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (arm) begin
         state_d     = S_WAIT;
         prev_ok_d   = 1'b0;
         to_cnt_d    = '0;
         auto_trig_d = 1'b0;
         one_shot_d  = single & ~run;
      end

      busy_d = (state_d == S_WAIT) | (state_d == S_CAP);
   end

   // State and output registers; reset discards any partial frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         prev_q        <= '0;
         prev_ok_q     <= 1'b0;
         to_cnt_q      <= '0;
         one_shot_q    <= 1'b0;
         dec_q         <= '0;
         dec_cnt_q     <= '0;
         addr_q        <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         auto_trig_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         prev_ok_q     <= prev_ok_d;
         to_cnt_q      <= to_cnt_d;
         one_shot_q    <= one_shot_d;
         dec_q         <= dec_d;
         dec_cnt_q     <= dec_cnt_d;
         addr_q        <= addr_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_ready_q <= frame_ready_d;
         busy_q        <= busy_d;
         auto_trig_q   <= auto_trig_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_ready = frame_ready_q;
   assign busy        = busy_q;
   assign auto_trig   = auto_trig_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// tb_acq_trigger_ctrl: directed and randomized checks of acq_trigger_ctrl
// against a behavioural acquisition model (DEPTH=16, TO_SH=8).
module tb_acq_trigger_ctrl;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [11:0] trigger = 12'd2048;
   logic [11:0] count_adc = 12'd1;
   logic [11:0] trig_clk = '0;
   logic        run = 1'b0;
   logic        single = 1'b0;
   logic        frame_ack = 1'b0;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [11:0] wr_data;
   logic        frame_ready;
   logic        busy;
   logic        auto_trig;

   acq_trigger_ctrl #(
      .ADC_W (12),
      .ADDR_W(4),
      .TO_SH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .trigger    (trigger),
      .count_adc  (count_adc),
      .trig_clk   (trig_clk),
      .run        (run),
      .single     (single),
      .frame_ack  (frame_ack),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_ready(frame_ready),
      .busy       (busy),
      .auto_trig  (auto_trig)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_HOLD = 3;
   int m_mode, m_prev, m_nval, m_dec, m_since, m_writes;
   bit m_have, m_one;
   int e_wr_en, e_wr_addr, e_wr_data, e_ready, e_busy, e_auto;

   task automatic model_reset();
      m_mode = M_IDLE; m_prev = 0; m_nval = 0; m_dec = 1;
      m_since = 0; m_writes = 0; m_have = 0; m_one = 0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0;
      e_ready = 0; e_busy = 0; e_auto = 0;
   endtask

   task automatic model_arm();
      m_mode = M_ARMED; m_have = 0; m_nval = 0; e_auto = 0;
      m_one = single && !run;
   endtask

   task automatic emit(input int a, input int d);
      e_wr_en = 1; e_wr_addr = a; e_wr_data = d;
   endtask

   task automatic model_step();
      bit crossed, timed;
      e_wr_en = 0;
      case (m_mode)
         M_IDLE: if (run || single) model_arm();
         M_ARMED: if (adc_valid) begin
            crossed = m_have && (m_prev < int'(trigger)) && (int'(adc_data) >= int'(trigger));
            if (m_nval < 20'hFFFFF) m_nval++;
            timed = (trig_clk != 0) && (m_nval >= int'(trig_clk) * 256);
            m_prev = int'(adc_data); m_have = 1;
            if (crossed || timed) begin
               e_auto = !crossed;
               m_mode = M_CAP;
               m_dec = (count_adc == 0) ? 1 : int'(count_adc);
               m_since = 0;
               emit(0, int'(adc_data));
               m_writes = 1;
            end
         end
         M_CAP: if (adc_valid) begin
            m_since++;
            if (m_since == m_dec) begin
               m_since = 0;
               emit(m_writes, int'(adc_data));
               m_writes++;
               if (m_writes == DEPTH) begin
                  m_mode = M_HOLD;
                  e_ready = 1;
               end
            end
         end
         M_HOLD: if (frame_ack) begin
            e_ready = 0;
            if (run && !m_one) model_arm();
            else m_mode = M_IDLE;
         end
         default: m_mode = M_IDLE;
      endcase
      e_busy = (m_mode == M_ARMED || m_mode == M_CAP) ? 1 : 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare + write log ----------------
   typedef struct { int a; int d; } wr_t;
   wr_t wq[$];

   initial begin
      forever begin
         @(negedge clk);
         chk("wr_en", wr_en, e_wr_en);
         if (e_wr_en != 0) begin
            chk("wr_addr", wr_addr, e_wr_addr);
            chk("wr_data", wr_data, e_wr_data);
         end
         chk("frame_ready", frame_ready, e_ready);
         chk("busy", busy, e_busy);
         chk("auto_trig", auto_trig, e_auto);
         if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data)});
      end
   end

   function automatic int wd(input int i);
      if (i < wq.size()) return wq[i].d;
      return -1;
   endfunction

   function automatic int wa(input int i);
      if (i < wq.size()) return wq[i].a;
      return -1;
   endfunction

   // ---------------- stimulus helpers ----------------
   logic [11:0] ramp = '0;

   task automatic tick(input bit v);
      @(negedge clk);
      adc_valid = v;
      if (v) begin
         adc_data = ramp;
         ramp = ramp + 12'd16;
      end
   endtask

   task automatic tickd(input bit v, input int d);
      @(negedge clk);
      adc_valid = v;
      adc_data = 12'(d);
   endtask

   task automatic wait_ready(input int maxc, input int pct);
      for (int i = 0; i < maxc; i++) begin
         tick($urandom_range(0, 99) < pct);
         if (frame_ready) break;
      end
      chk("frame_ready_wait", frame_ready, 1);
   endtask

   task automatic wait_addr(input int a, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         tick(1);
         if (wr_en && wr_addr == 4'(a)) break;
      end
      chk("wait_addr", (wr_en && wr_addr == 4'(a)) ? 1 : 0, 1);
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      tick(0);
      frame_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      run = 0; single = 0; frame_ack = 0; adc_valid = 0;
      trigger = 12'd2048; count_adc = 12'd1; trig_clk = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      wq.delete();
      ramp = '0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit lowmode;
      int n;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_auto_trig", auto_trig, 0);
      #2 rst = 1'b1;

      // rising crossing, no decimation
      run = 1;
      wait_ready(600, 100);
      chk("cross_ready", frame_ready, 1);
      chk("cross_auto", auto_trig, 0);
      ack();
      chk("cross_nwr", wq.size(), 16);
      chk("cross_a0", wa(0), 0);
      chk("cross_d0", wd(0), 2048);
      chk("cross_d1", wd(1), 2064);
      chk("cross_a15", wa(15), 15);
      chk("cross_d15", wd(15), 2288);

      // decimation by 4 with gaps in adc_valid
      do_reset();
      count_adc = 12'd4; run = 1;
      wait_ready(3000, 70);
      ack();
      chk("dec_nwr", wq.size(), 16);
      chk("dec_d0", wd(0), 2048);
      chk("dec_d1", wd(1), 2112);
      chk("dec_d2", wd(2), 2176);
      chk("dec_d15", wd(15), 3008);

      // auto trigger after 256 valid samples below the level
      do_reset();
      trig_clk = 12'd1; run = 1;
      tick(0); tick(0);
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         tickd(1, i);
         n = i;
         if (frame_ready) break;
      end
      chk("auto_ready", frame_ready, 1);
      chk("auto_flag", auto_trig, 1);
      ack();
      chk("auto_d0", wd(0), 256);
      chk("auto_d15", wd(15), 271);

      // normal mode never auto-triggers
      do_reset();
      run = 1;
      for (int i = 0; i < 5000; i++) tickd(1, 100);
      chk("norm_nwr", wq.size(), 0);
      chk("norm_busy", busy, 1);

      // single shot, with an ignored single mid-capture
      do_reset();
      single = 1; tick(0); single = 0;
      wait_addr(3, 600);
      single = 1; tick(1); single = 0;
      wait_ready(200, 100);
      ack();
      for (int i = 0; i < 300; i++) tick(1);
      chk("single_nwr", wq.size(), 16);
      chk("single_busy", busy, 0);
      chk("single_ready", frame_ready, 0);

      // first sample above level, then only falling samples
      do_reset();
      tickd(1, 100);
      run = 1; tickd(0, 0);
      for (int v = 3000; v >= 0; v -= 16) tickd(1, v);
      chk("edge_nwr", wq.size(), 0);
      chk("edge_busy", busy, 1);

      // decimation change mid-capture is ignored
      do_reset();
      run = 1;
      wait_addr(4, 600);
      count_adc = 12'd8;
      wait_ready(200, 100);
      ack();
      chk("decchg_nwr", wq.size(), 16);
      chk("decchg_d8", wd(8), 2176);
      chk("decchg_d15", wd(15), 2288);

      // asynchronous reset mid-capture
      do_reset();
      run = 1;
      wait_addr(7, 600);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_wr_en", wr_en, 0);
      chk("arst_wr_addr", wr_addr, 0);
      chk("arst_wr_data", wr_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", frame_ready, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      wq.delete();
      wait_ready(700, 100);
      ack();
      chk("arst_nwr", wq.size(), 16);
      chk("arst_a0", wa(0), 0);
      chk("arst_d0", wd(0), 2048);

      // randomized operation against the model
      do_reset();
      for (int b = 0; b < 8; b++) begin
         trigger   = 12'($urandom);
         count_adc = 12'($urandom_range(0, 3));
         trig_clk  = 12'($urandom_range(0, 1));
         lowmode   = ($urandom_range(0, 3) == 0);
         run       = 1;
         for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 3) run = ~run;
            single    = ($urandom_range(0, 99) < 3);
            frame_ack = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 2) count_adc = 12'($urandom_range(0, 3));
            if (lowmode) n = (trigger > 0) ? $urandom_range(0, int'(trigger) - 1) : 0;
            else n = $urandom_range(0, 4095);
            tickd($urandom_range(0, 99) < 75, n);
         end
         single = 0; frame_ack = 0;
      end
      tick(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
